// File: rtl/act_unpack.sv
// act_unpack: serialises a packed word of four 8-bit activations into 16-bit
// MAC operands, one byte per cycle (byte0 first). Positive bytes above the
// selected limit are clamped, and clamped emissions are counted (saturating).
module act_unpack (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Unpk_Din,
  input  logic        Unpk_Din_vld,
  input  logic        Unpk_Din_last,
  input  logic [1:0]  Unpk_Din_bcnt,
  input  logic        Unpk_max,
  input  logic        Unpk_sat_clr,
  output logic        Unpk_Din_rdy,
  output logic [15:0] Unpk_Dout,
  output logic        Unpk_Dout_vld,
  output logic        Unpk_Dout_last,
  input  logic        Unpk_Dout_rdy,
  output logic [7:0]  Unpk_sat_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic        last_q, last_d;
  logic [2:0]  bcnt_q, bcnt_d;     // bytes in the held word, 1..4
  logic        max_q, max_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] dout_q, dout_d;
  logic        vld_q, vld_d;
  logic        dlast_q, dlast_d;
  logic        clamp_q, clamp_d;   // the byte currently presented was clamped
  logic [7:0]  sat_q, sat_d;

  logic        din_rdy_s;
  logic        final_s;
  logic        out_hs_s;
  logic        in_acc_s;
  logic [7:0]  byte_s;
  logic [7:0]  emit_s;

  // Clamp limit selected by the max flag held with the word.
  function automatic logic [7:0] clamp_limit(input logic max_sel);
    logic [7:0] lim;
    if (max_sel) begin
      lim = 8'h40;
    end else begin
      lim = 8'h20;
    end
    return lim;
  endfunction

  // Only non-negative bytes above the limit are clamped; negatives pass.
  function automatic logic is_clamped(input logic [7:0] b, input logic max_sel);
    return (b[7] == 1'b0) && (b > clamp_limit(max_sel));
  endfunction

  function automatic logic [7:0] clamp_byte(input logic [7:0] b, input logic max_sel);
    logic [7:0] e;
    if (is_clamped(b, max_sel)) begin
      e = clamp_limit(max_sel);
    end else begin
      e = b;
    end
    return e;
  endfunction

  // Sign-extended byte scaled by 32 into the MAC operand format.
  function automatic logic [15:0] expand_byte(input logic [7:0] e);
    return {{4{e[7]}}, e[6:0], 5'b00000};
  endfunction

  // A last word with bcnt=0 carries four bytes; non-last words always four.
  function automatic logic [2:0] word_bytes(input logic last, input logic [1:0] bcnt);
    logic [2:0] n;
    if (last && (bcnt != 2'd0)) begin
      n = {1'b0, bcnt};
    end else begin
      n = 3'd4;
    end
    return n;
  endfunction

  assign final_s  = (({1'b0, idx_q} + 3'd1) == bcnt_q);
  assign out_hs_s = vld_q & Unpk_Dout_rdy;
  assign in_acc_s = Unpk_Din_vld & din_rdy_s;

  // Upstream ready: free when idle, or when the last byte leaves this cycle.
  always_comb begin
    din_rdy_s = 1'b0;
    if (rst) begin
      din_rdy_s = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE:  din_rdy_s = 1'b1;
        ST_SHIFT: din_rdy_s = final_s & Unpk_Dout_rdy;
        default:  din_rdy_s = 1'b0;
      endcase
    end
  end

  assign Unpk_Din_rdy = din_rdy_s;

  // Next word/index/state; an accepted word always restarts at byte0.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    max_d   = max_q;
    idx_d   = idx_q;
    if (in_acc_s) begin
      state_d = ST_SHIFT;
      word_d  = Unpk_Din;
      last_d  = Unpk_Din_last;
      bcnt_d  = word_bytes(Unpk_Din_last, Unpk_Din_bcnt);
      max_d   = Unpk_max;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_SHIFT: begin
          if (out_hs_s && !final_s) begin
            idx_d = idx_q + 2'd1;
          end else if (out_hs_s) begin
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output image of the byte that will be presented next cycle.
  always_comb begin
    case (idx_d)
      2'd0:    byte_s = word_d[7:0];
      2'd1:    byte_s = word_d[15:8];
      2'd2:    byte_s = word_d[23:16];
      2'd3:    byte_s = word_d[31:24];
      default: byte_s = word_d[7:0];
    endcase
    emit_s  = clamp_byte(byte_s, max_d);
    clamp_d = is_clamped(byte_s, max_d);
    dout_d  = expand_byte(emit_s);
    vld_d   = (state_d == ST_SHIFT);
    dlast_d = vld_d & last_d & (({1'b0, idx_d} + 3'd1) == bcnt_d);
  end

  // Saturating clamp counter; a clear beats a coincident clamped handshake.
  always_comb begin
    if (Unpk_sat_clr) begin
      sat_d = 8'd0;
    end else if (out_hs_s && clamp_q && (sat_q != 8'hFF)) begin
      sat_d = sat_q + 8'd1;
    end else begin
      sat_d = sat_q;
    end
  end

  // State and registered outputs; reset discards any word in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= 32'd0;
      last_q  <= 1'b0;
      bcnt_q  <= 3'd0;
      max_q   <= 1'b0;
      idx_q   <= 2'd0;
      dout_q  <= 16'd0;
      vld_q   <= 1'b0;
      dlast_q <= 1'b0;
      clamp_q <= 1'b0;
      sat_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      dlast_q <= dlast_d;
      clamp_q <= clamp_d;
      sat_q   <= sat_d;
    end
  end

  assign Unpk_Dout      = dout_q;
  assign Unpk_Dout_vld  = vld_q;
  assign Unpk_Dout_last = dlast_q;
  assign Unpk_sat_cnt   = sat_q;

endmodule

// File: tb/tb_act_unpack.sv
// tb_act_unpack: directed scenarios plus randomized traffic for act_unpack,
// checked against a queue-based model of the emitted halfword stream.
module tb_act_unpack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] din = 32'd0;
  logic        din_vld = 1'b0;
  logic        din_last = 1'b0;
  logic [1:0]  din_bcnt = 2'd0;
  logic        max_s = 1'b0;
  logic        sat_clr = 1'b0;
  logic        dout_rdy = 1'b1;
  logic        Unpk_Din_rdy;
  logic [15:0] Unpk_Dout;
  logic        Unpk_Dout_vld;
  logic        Unpk_Dout_last;
  logic [7:0]  Unpk_sat_cnt;

  always #5 clk = ~clk;

  act_unpack dut (
    .clk           (clk),
    .rst           (rst),
    .Unpk_Din      (din),
    .Unpk_Din_vld  (din_vld),
    .Unpk_Din_last (din_last),
    .Unpk_Din_bcnt (din_bcnt),
    .Unpk_max      (max_s),
    .Unpk_sat_clr  (sat_clr),
    .Unpk_Din_rdy  (Unpk_Din_rdy),
    .Unpk_Dout     (Unpk_Dout),
    .Unpk_Dout_vld (Unpk_Dout_vld),
    .Unpk_Dout_last(Unpk_Dout_last),
    .Unpk_Dout_rdy (dout_rdy),
    .Unpk_sat_cnt  (Unpk_sat_cnt)
  );

  typedef struct {
    logic [15:0] d;
    bit          last;
    bit          clamp;
  } hw_t;

  hw_t         q[$];          // halfwords still to be emitted, head = on the bus
  int          sat_m = 0;
  int          total = 0;
  int          bad = 0;
  logic        seen_rdy, exp_rdy, exp_vld, exp_last;
  logic [15:0] exp_dout = 16'd0;
  logic [7:0]  exp_sat = 8'd0;

  // Reference: clamp by numeric comparison, then value * 32 as signed 16-bit.
  function automatic hw_t mk(input logic [7:0] b, input logic mx, input bit lst);
    hw_t h;
    int  lim;
    int  v;
    byte sb;
    lim     = mx ? 64 : 32;
    h.clamp = (int'(b) < 128) && (int'(b) > lim);
    sb      = h.clamp ? byte'(lim) : byte'(b);
    v       = sb * 32;
    h.d     = v[15:0];
    h.last  = lst;
    return h;
  endfunction

  task automatic push_word(input logic [31:0] w, input logic lst, input logic [1:0] bc, input logic mx);
    int n;
    n = (lst && bc != 2'd0) ? int'(bc) : 4;
    for (int i = 0; i < n; i++) q.push_back(mk(w[8*i +: 8], mx, lst && (i == n - 1)));
  endtask

  // One clock: sample ready, advance the model on the edge, settle expectations.
  task automatic tick();
    bit hs, acc, clp;
    #1;
    seen_rdy = Unpk_Din_rdy;
    exp_rdy  = (q.size() == 0) || (q.size() == 1 && dout_rdy);
    hs       = (q.size() > 0) && dout_rdy;
    clp      = hs && q[0].clamp;
    acc      = din_vld && exp_rdy;
    if (hs) void'(q.pop_front());
    if (acc) push_word(din, din_last, din_bcnt, max_s);
    if (sat_clr) sat_m = 0;
    else if (clp && sat_m < 255) sat_m++;
    @(posedge clk);
    #1;
    exp_vld  = (q.size() > 0);
    exp_last = exp_vld ? q[0].last : 1'b0;
    if (exp_vld) exp_dout = q[0].d;
    exp_sat  = 8'(sat_m);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #3;
    total++; if (Unpk_Din_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b exp=0", Unpk_Din_rdy); end
    total++; if (Unpk_Dout_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b exp=0", Unpk_Dout_vld); end
    total++; if (Unpk_Dout !== 16'h0000) begin bad++; $display("FAIL reset_dout got=%h exp=0000", Unpk_Dout); end
    total++; if (Unpk_Dout_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", Unpk_Dout_last); end
    total++; if (Unpk_sat_cnt !== 8'd0) begin bad++; $display("FAIL reset_sat got=%0d exp=0", Unpk_sat_cnt); end
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete(); sat_m = 0;
    tick();
    total++; if (Unpk_Din_rdy !== 1'b1) begin bad++; $display("FAIL reset_release_rdy got=%b exp=1", Unpk_Din_rdy); end
    total++; if (Unpk_Dout_vld !== 1'b0) begin bad++; $display("FAIL reset_release_vld got=%b exp=0", Unpk_Dout_vld); end
  endtask

  task automatic test_basic();
    logic [15:0] c [4] = '{16'h0020, 16'h00A0, 16'h03E0, 16'h0800};
    din = 32'h401F0501; din_last = 1'b0; max_s = 1'b1; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if (Unpk_Dout_vld !== 1'b1) begin bad++; $display("FAIL basic_vld k=%0d got=%b exp=1", k, Unpk_Dout_vld); end
      total++; if (Unpk_Dout !== c[k]) begin bad++; $display("FAIL basic_dout k=%0d got=%h exp=%h", k, Unpk_Dout, c[k]); end
      total++; if (Unpk_Dout_last !== 1'b0) begin bad++; $display("FAIL basic_last k=%0d got=%b exp=0", k, Unpk_Dout_last); end
      tick();
      total++; if (seen_rdy !== (k == 3)) begin bad++; $display("FAIL basic_rdy k=%0d got=%b exp=%b", k, seen_rdy, k == 3); end
    end
    total++; if (Unpk_Dout_vld !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b exp=0", Unpk_Dout_vld); end
    total++; if (Unpk_sat_cnt !== 8'd0) begin bad++; $display("FAIL basic_sat got=%0d exp=0", Unpk_sat_cnt); end
  endtask

  task automatic test_clamp();
    din = 32'h00000030; din_last = 1'b1; din_bcnt = 2'd1; max_s = 1'b0; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    total++; if (Unpk_Dout !== 16'h0400) begin bad++; $display("FAIL clamp_lo_dout got=%h exp=0400", Unpk_Dout); end
    total++; if (Unpk_Dout_last !== 1'b1) begin bad++; $display("FAIL clamp_lo_last got=%b exp=1", Unpk_Dout_last); end
    tick();
    total++; if (Unpk_sat_cnt !== 8'd1) begin bad++; $display("FAIL clamp_lo_sat got=%0d exp=1", Unpk_sat_cnt); end
    din = 32'h00003030; din_bcnt = 2'd2; max_s = 1'b1; din_vld = 1'b1;
    tick();
    din_vld = 1'b0; max_s = 1'b0;
    for (int k = 0; k < 2; k++) begin
      total++; if (Unpk_Dout !== 16'h0600) begin bad++; $display("FAIL clamp_hi_dout k=%0d got=%h exp=0600", k, Unpk_Dout); end
      tick();
    end
    total++; if (Unpk_sat_cnt !== 8'd1) begin bad++; $display("FAIL clamp_hi_sat got=%0d exp=1", Unpk_sat_cnt); end
    total++; if (Unpk_Dout_vld !== 1'b0) begin bad++; $display("FAIL clamp_idle got=%b exp=0", Unpk_Dout_vld); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] c [8] = '{16'h0220, 16'hF020, 16'hFE00, 16'h0140, 16'h0400, 16'h0400, 16'h02A0, 16'h0000};
    din = 32'h0AF08111; din_last = 1'b0; max_s = 1'b1; din_vld = 1'b1;
    tick();
    din = 32'h00152021; max_s = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++; if (Unpk_Dout_vld !== 1'b1) begin bad++; $display("FAIL b2b_vld k=%0d got=%b exp=1", k, Unpk_Dout_vld); end
      total++; if (Unpk_Dout !== c[k]) begin bad++; $display("FAIL b2b_dout k=%0d got=%h exp=%h", k, Unpk_Dout, c[k]); end
      tick();
      total++; if (seen_rdy !== (k == 3 || k == 7)) begin bad++; $display("FAIL b2b_rdy k=%0d got=%b exp=%b", k, seen_rdy, k == 3 || k == 7); end
      if (k == 3) din_vld = 1'b0;
    end
    total++; if (Unpk_Dout_vld !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", Unpk_Dout_vld); end
    total++; if (Unpk_sat_cnt !== 8'd2) begin bad++; $display("FAIL b2b_sat got=%0d exp=2", Unpk_sat_cnt); end
  endtask

  task automatic test_last();
    logic [15:0] c [4] = '{16'h0020, 16'h0040, 16'h0060, 16'h0080};
    din = 32'hAABB3C07; din_last = 1'b1; din_bcnt = 2'd2; max_s = 1'b1; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    total++; if (Unpk_Dout !== 16'h00E0 || Unpk_Dout_last !== 1'b0) begin bad++; $display("FAIL last2_b0 got=%h/%b exp=00e0/0", Unpk_Dout, Unpk_Dout_last); end
    tick();
    total++; if (Unpk_Dout !== 16'h0780 || Unpk_Dout_last !== 1'b1) begin bad++; $display("FAIL last2_b1 got=%h/%b exp=0780/1", Unpk_Dout, Unpk_Dout_last); end
    tick();
    total++; if (Unpk_Dout_vld !== 1'b0) begin bad++; $display("FAIL last2_idle got=%b exp=0", Unpk_Dout_vld); end
    total++; if (Unpk_Din_rdy !== 1'b1) begin bad++; $display("FAIL last2_rdy got=%b exp=1", Unpk_Din_rdy); end
    din = 32'h04030201; din_bcnt = 2'd0; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if (Unpk_Dout !== c[k]) begin bad++; $display("FAIL last4_dout k=%0d got=%h exp=%h", k, Unpk_Dout, c[k]); end
      total++; if (Unpk_Dout_last !== (k == 3)) begin bad++; $display("FAIL last4_last k=%0d got=%b exp=%b", k, Unpk_Dout_last, k == 3); end
      tick();
    end
    total++; if (Unpk_Dout_vld !== 1'b0) begin bad++; $display("FAIL last4_idle got=%b exp=0", Unpk_Dout_vld); end
    din_last = 1'b0;
  endtask

  task automatic test_stall();
    logic [15:0] c [4] = '{16'h0220, 16'h0440, 16'h0660, 16'h0800};
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int idx = 0;
    din = 32'h44332211; din_last = 1'b0; max_s = 1'b1; din_vld = 1'b1;
    tick();
    din = 32'h01010101;
    for (int s = 0; s < 7; s++) begin
      dout_rdy = pat[s];
      total++; if (Unpk_Dout !== c[idx] || Unpk_Dout_vld !== 1'b1) begin bad++; $display("FAIL stall_dout s=%0d got=%h/%b exp=%h/1", s, Unpk_Dout, Unpk_Dout_vld, c[idx]); end
      tick();
      total++; if (seen_rdy !== (idx == 3 && pat[s])) begin bad++; $display("FAIL stall_rdy s=%0d got=%b exp=%b", s, seen_rdy, idx == 3 && pat[s]); end
      if (pat[s]) idx++;
      if (idx == 4) din_vld = 1'b0;
    end
    dout_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (Unpk_Dout !== 16'h0020 || Unpk_Dout_vld !== 1'b1) begin bad++; $display("FAIL stall_next k=%0d got=%h/%b exp=0020/1", k, Unpk_Dout, Unpk_Dout_vld); end
      tick();
    end
    total++; if (Unpk_Dout_vld !== 1'b0) begin bad++; $display("FAIL stall_idle got=%b exp=0", Unpk_Dout_vld); end
    total++; if (Unpk_sat_cnt !== 8'd3) begin bad++; $display("FAIL stall_sat got=%0d exp=3", Unpk_sat_cnt); end
  endtask

  task automatic test_reset_mid();
    din = 32'h10302010; din_last = 1'b0; max_s = 1'b1; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    tick();
    tick();
    total++; if (Unpk_Dout !== 16'h0600) begin bad++; $display("FAIL rstmid_pre got=%h exp=0600", Unpk_Dout); end
    #2 rst = 1'b1;
    #1;
    total++; if (Unpk_Dout !== 16'h0000 || Unpk_Dout_vld !== 1'b0 || Unpk_Dout_last !== 1'b0) begin bad++; $display("FAIL rstmid_out got=%h/%b/%b exp=0000/0/0", Unpk_Dout, Unpk_Dout_vld, Unpk_Dout_last); end
    total++; if (Unpk_sat_cnt !== 8'd0) begin bad++; $display("FAIL rstmid_sat got=%0d exp=0", Unpk_sat_cnt); end
    total++; if (Unpk_Din_rdy !== 1'b0) begin bad++; $display("FAIL rstmid_rdy got=%b exp=0", Unpk_Din_rdy); end
    rst = 1'b0;
    q.delete(); sat_m = 0;
    din = 32'h04030203; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    total++; if (seen_rdy !== 1'b1) begin bad++; $display("FAIL rstmid_rdy_after got=%b exp=1", seen_rdy); end
    total++; if (Unpk_Dout !== 16'h0060 || Unpk_Dout_vld !== 1'b1) begin bad++; $display("FAIL rstmid_byte0 got=%h/%b exp=0060/1", Unpk_Dout, Unpk_Dout_vld); end
    for (int k = 0; k < 4; k++) tick();
    total++; if (Unpk_Dout_vld !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b exp=0", Unpk_Dout_vld); end
  endtask

  task automatic test_saturate();
    din = 32'h7F7F7F7F; din_last = 1'b0; max_s = 1'b0; din_vld = 1'b1;
    for (int i = 0; i < 270; i++) begin
      tick();
      total++; if (Unpk_sat_cnt !== exp_sat) begin bad++; $display("FAIL sat_count i=%0d got=%0d exp=%0d", i, Unpk_sat_cnt, exp_sat); end
    end
    din_vld = 1'b0;
    for (int i = 0; i < 8 && exp_vld; i++) tick();
    total++; if (Unpk_sat_cnt !== 8'd255) begin bad++; $display("FAIL sat_full got=%0d exp=255", Unpk_sat_cnt); end
    din_last = 1'b1; din_bcnt = 2'd1; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    tick();
    total++; if (Unpk_sat_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d exp=255", Unpk_sat_cnt); end
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0; sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    total++; if (Unpk_sat_cnt !== 8'd0) begin bad++; $display("FAIL sat_clr_wins got=%0d exp=0", Unpk_sat_cnt); end
    din_last = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      din      = $urandom;
      din_vld  = ($urandom_range(0, 9) < 7);
      din_last = $urandom_range(0, 1);
      din_bcnt = 2'($urandom_range(0, 3));
      max_s    = $urandom_range(0, 1);
      dout_rdy = ($urandom_range(0, 3) != 0);
      sat_clr  = ($urandom_range(0, 49) == 0);
      tick();
      total++; if (seen_rdy !== exp_rdy) begin bad++; $display("FAIL rnd_rdy i=%0d got=%b exp=%b", i, seen_rdy, exp_rdy); end
      total++; if (Unpk_Dout_vld !== exp_vld) begin bad++; $display("FAIL rnd_vld i=%0d got=%b exp=%b", i, Unpk_Dout_vld, exp_vld); end
      total++; if (Unpk_Dout_last !== exp_last) begin bad++; $display("FAIL rnd_last i=%0d got=%b exp=%b", i, Unpk_Dout_last, exp_last); end
      total++; if (Unpk_sat_cnt !== exp_sat) begin bad++; $display("FAIL rnd_sat i=%0d got=%0d exp=%0d", i, Unpk_sat_cnt, exp_sat); end
      if (exp_vld) begin
        total++; if (Unpk_Dout !== exp_dout) begin bad++; $display("FAIL rnd_dout i=%0d got=%h exp=%h", i, Unpk_Dout, exp_dout); end
      end
    end
    din_vld = 1'b0; sat_clr = 1'b0; dout_rdy = 1'b1;
    for (int i = 0; i < 8 && exp_vld; i++) tick();
    total++; if (Unpk_Dout_vld !== 1'b0) begin bad++; $display("FAIL rnd_drain got=%b exp=0", Unpk_Dout_vld); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_back_to_back();
    test_last();
    test_stall();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/act_unpack.md
ACT_UNPACK -- requirements
Module: act_unpack

Interface
REQ-001 SHALL have no parameters; all widths below are fixed.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Unpk_Din  input  32  packed word of four 8-bit activations; byte0 = [7:0] is emitted first.
REQ-005 SHALL have port Unpk_Din_vld  input  1  word valid.
REQ-006 SHALL have port Unpk_Din_last  input  1  word is the last of its tile; qualified by Unpk_Din_vld.
REQ-007 SHALL have port Unpk_Din_bcnt  input  2  valid bytes in a last word; 0 means 4; ignored when Unpk_Din_last=0.
REQ-008 SHALL have port Unpk_max  input  1  clamp select: 1 selects limit 8'h40, 0 selects 8'h20; sampled with the word.
REQ-009 SHALL have port Unpk_sat_clr  input  1  synchronous clear of the saturation counter.
REQ-010 SHALL have port Unpk_Din_rdy  output  1  word accepted on a cycle where vld=1 and rdy=1.
REQ-011 SHALL have port Unpk_Dout  output  16  expanded halfword for the MAC array.
REQ-012 SHALL have port Unpk_Dout_vld  output  1  halfword valid.
REQ-013 SHALL have port Unpk_Dout_last  output  1  final halfword of a last word.
REQ-014 SHALL have port Unpk_Dout_rdy  input  1  downstream accepts on a cycle where vld=1 and rdy=1.
REQ-015 SHALL have port Unpk_sat_cnt  output  8  count of clamped bytes emitted; saturates at 255.

Function
REQ-016 SHALL implement two states. IDLE: no word held. SHIFT: a word is held and its bytes are being emitted.
REQ-017 In IDLE, SHALL drive Unpk_Din_rdy=1 and Unpk_Dout_vld=0. On accept, SHALL register the word, last, byte count (0 mapped to 4) and Unpk_max, set byte index=0, and go to SHIFT.
REQ-018 In SHIFT, SHALL drive Unpk_Dout_vld=1 from registers; Unpk_Dout_vld SHALL be asserted the cycle after acceptance (latency 1).
REQ-019 SHALL hold Unpk_Dout, Unpk_Dout_vld and Unpk_Dout_last stable while vld=1 and Unpk_Dout_rdy=0.
REQ-020 On a downstream handshake of a non-final byte, SHALL increment the byte index.
REQ-021 In SHIFT, SHALL drive Unpk_Din_rdy=1 only when the current byte is the final byte of the word and Unpk_Dout_rdy=1.
REQ-022 On a final-byte handshake with simultaneous word accept, SHALL load the new word and stay in SHIFT, giving gapless streaming at one halfword per cycle.
REQ-023 On a final-byte handshake with no word accept, SHALL return to IDLE.
REQ-024 SHALL clamp each byte b as follows: if b[7]=0 and b > limit, the emitted byte is limit; otherwise it is b unchanged (negative bytes pass).
REQ-025 SHALL expand the emitted byte e as Unpk_Dout = {4 copies of e[7], e[6:0], 5'b0}, placing e[6:0] at bits [11:5].
REQ-026 SHALL assert Unpk_Dout_last only on the final byte of a word registered with last=1.
REQ-027 SHALL increment Unpk_sat_cnt once per downstream handshake of a clamped byte, holding at 255.
REQ-028 If Unpk_sat_clr and a clamped handshake coincide, the clear SHALL win and the result SHALL be 0.
REQ-029 Changes on Unpk_max while in SHIFT SHALL NOT affect the held word.

Reset
REQ-030 On rst=1, SHALL immediately force state=IDLE, byte index=0, Unpk_Dout=0, Unpk_Dout_vld=0, Unpk_Dout_last=0, Unpk_sat_cnt=0, and all word registers=0.
REQ-031 While rst=1, SHALL drive Unpk_Din_rdy=0. A word in progress at reset SHALL be discarded without emission.
REQ-032 On the first clock edge after rst falls, SHALL be in IDLE with Unpk_Din_rdy=1.

Verification
REQ-033 Scenario: word 32'h40_1F_05_01, max=1, Dout_rdy=1 -> 0x0020, 0x00A0, 0x03E0, 0x0800 on four consecutive cycles; sat_cnt=0.
REQ-034 Scenario: byte 8'h30 with max=0 -> emitted 0x0400 (clamped to 8'h20), sat_cnt=1; the same byte with max=1 -> 0x0600, no increment.
REQ-035 Scenario: byte 8'hF0 -> 0xFE00, no clamp. Two back-to-back words with Dout_rdy=1 -> 8 halfwords with no bubble and Din_rdy high on cycles 4 and 8 only.
REQ-036 Scenario: last word with bcnt=2 -> exactly 2 halfwords, Dout_last on the 2nd; then IDLE. Last word with bcnt=0 -> 4 halfwords.
REQ-037 Scenario: Dout_rdy low for 3 cycles mid-word -> Dout is held unchanged, no byte is skipped or duplicated, and Din_rdy stays 0.
REQ-038 Scenario: rst asserted between clock edges while in SHIFT at byte index 2 -> outputs 0 immediately; after release, the next word starts at its byte0. Sat count of 255 plus a clamp -> stays 255; sat_clr coinciding with a clamp -> 0.
